// File: rtl/memory_playback_pkg.sv
// Shared definitions for the playback buffer: FSM encoding, default geometry and
// the buffer depth shared with the capture buffer.
package memory_playback_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned BUF_DEPTH  = 1 << ADDR_W_DEF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/memory_playback_ram.sv
// Simple dual-port block RAM with a registered (1-cycle) synchronous read port.
module memory_playback_ram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [1 << ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/memory_playback.sv
// Host-loaded playback buffer: streams stored words in write order into a downstream
// FIFO through a 2-entry skid buffer, honouring fifo_full; contents survive for replay.
module memory_playback
  import memory_playback_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_wr_i,
  input  logic [DATA_W-1:0] host_data_i,
  input  logic              clr_i,
  input  logic              start_i,
  input  logic              fifo_full_i,
  output logic              fifo_wr_o,
  output logic [DATA_W-1:0] fifo_din_o,
  output logic [ADDR_W:0]   level_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              wr_err_o
);

  localparam int unsigned LW = ADDR_W + 1;
  localparam logic [LW-1:0] FullLevel = LW'(depth_of(ADDR_W));

  state_e            state_q;
  logic              busy_q, done_q;
  logic              wr_err_q, wr_err_d;
  logic [LW-1:0]     level_q, level_d;
  logic [LW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     sent_q, sent_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] skid0_q, skid0_d, skid1_q, skid1_d;
  logic [DATA_W-1:0] ram_rdata;
  logic [2:0]        pending;
  logic              run, pop, push, rd_en;
  logic              wr_accept, wr_drop, start_run, start_empty;

  assign run  = (state_q == S_RUN);
  assign pop  = (occ_q != 2'd0) && !fifo_full_i;
  assign push = rvalid_q;

  assign wr_accept = host_wr_i && !clr_i && !run && (level_q != FullLevel);
  assign wr_drop   = host_wr_i && !clr_i && !wr_accept;

  // A same-cycle host_wr is counted before deciding between RUN and DONE.
  assign start_run   = start_i && !clr_i && (state_q == S_IDLE) && (level_d != '0);
  assign start_empty = start_i && !clr_i && (state_q == S_IDLE) && (level_d == '0);

  // Skid slots already committed after this cycle's pop; keep below 2 to avoid overflow.
  assign pending = 3'(occ_q) + 3'(rvalid_q) - 3'(pop);
  assign rd_en   = run && !clr_i && (rd_ptr_q < level_q) && (pending < 3'd2);

  memory_playback_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_i     (clk),
    .wr_en_i   (wr_accept),
    .wr_addr_i (level_q[ADDR_W-1:0]),
    .wr_data_i (host_data_i),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
    .rd_data_o (ram_rdata)
  );

  always_comb begin
    level_d  = level_q;
    wr_err_d = wr_err_q;
    rd_ptr_d = rd_ptr_q;
    sent_d   = sent_q;
    rvalid_d = rd_en;
    occ_d    = occ_q;
    skid0_d  = skid0_q;
    skid1_d  = skid1_q;

    if (clr_i) begin
      level_d  = '0;
      wr_err_d = 1'b0;
      rd_ptr_d = '0;
      sent_d   = '0;
      occ_d    = 2'd0;
    end else begin
      if (wr_accept) begin
        level_d = level_q + LW'(1);
      end
      if (wr_drop) begin
        wr_err_d = 1'b1;
      end
      if (start_run) begin
        rd_ptr_d = '0;
        sent_d   = '0;
      end else begin
        if (rd_en) begin
          rd_ptr_d = rd_ptr_q + LW'(1);
        end
        if (pop) begin
          sent_d = sent_q + LW'(1);
        end
      end

      // Head only moves when a newer word replaces it, so fifo_din holds while idle.
      unique case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) begin
            skid0_d = ram_rdata;
          end else begin
            skid1_d = ram_rdata;
          end
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          if (occ_q == 2'd2) begin
            skid0_d = skid1_q;
          end
          occ_d = occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd2) begin
            skid0_d = skid1_q;
            skid1_d = ram_rdata;
          end else begin
            skid0_d = ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q  <= '0;
      wr_err_q <= 1'b0;
      rd_ptr_q <= '0;
      sent_q   <= '0;
      rvalid_q <= 1'b0;
      occ_q    <= 2'd0;
      skid0_q  <= '0;
      skid1_q  <= '0;
    end else begin
      level_q  <= level_d;
      wr_err_q <= wr_err_d;
      rd_ptr_q <= rd_ptr_d;
      sent_q   <= sent_d;
      rvalid_q <= rvalid_d;
      occ_q    <= occ_d;
      skid0_q  <= skid0_d;
      skid1_q  <= skid1_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clr_i) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start_run) begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end else if (start_empty) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
          S_RUN: begin
            // Leave on the final pop so done lands in the cycle after the last fifo_wr.
            if (pop && (sent_q + LW'(1) == level_q)) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign fifo_wr_o  = pop;
  assign fifo_din_o = skid0_q;
  assign level_o    = level_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign wr_err_o   = wr_err_q;

endmodule

// File: tb/tb_memory_playback.sv
// Scoreboarded bench for memory_playback: loaded words are queued on start and
// matched against every fifo_wr; per-scenario tasks check timing and status.
module tb_memory_playback;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              host_wr;
  logic [DATA_W-1:0] host_data;
  logic              clr;
  logic              start;
  logic              fifo_full;
  logic              fifo_wr;
  logic [DATA_W-1:0] fifo_din;
  logic [ADDR_W:0]   level;
  logic              busy;
  logic              done;
  logic              wr_err;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic [DATA_W-1:0] model_mem[$];
  logic [DATA_W-1:0] exp_q[$];

  int wr_count, done_count, first_wr_cyc, last_wr_cyc, done_cyc, start_cyc;

  memory_playback #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .host_wr_i   (host_wr),
    .host_data_i (host_data),
    .clr_i       (clr),
    .start_i     (start),
    .fifo_full_i (fifo_full),
    .fifo_wr_o   (fifo_wr),
    .fifo_din_o  (fifo_din),
    .level_o     (level),
    .busy_o      (busy),
    .done_o      (done),
    .wr_err_o    (wr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every FIFO write must match the next expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (fifo_wr === 1'b1) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_write: got data %h, required no write", fifo_din);
        end else begin
          logic [DATA_W-1:0] e;
          e = exp_q.pop_front();
          if (fifo_din !== e) begin
            tests_failed++;
            $display("FAIL stream_data: got %h, required %h (cycle %0d)", fifo_din, e, cyc);
          end
        end
        tests_run++;
        if (fifo_full !== 1'b0) begin
          tests_failed++;
          $display("FAIL write_while_full: got fifo_wr=1 with fifo_full=%b, required 0", fifo_full);
        end
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        wr_count++;
      end
      if (done === 1'b1) begin
        done_count++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    wr_count     = 0;
    done_count   = 0;
    first_wr_cyc = -1;
    last_wr_cyc  = -1;
    done_cyc     = -1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_mem.delete();
    exp_q.delete();
  endtask

  task automatic load_words(input int n, input logic [DATA_W-1:0] base);
    for (int i = 0; i < n; i++) begin
      host_wr   = 1'b1;
      host_data = base + DATA_W'(i);
      if (model_mem.size() < 1024) model_mem.push_back(base + DATA_W'(i));
      tick();
    end
    host_wr = 1'b0;
  endtask

  // Pulse start, queue the model contents, then run until done (bounded).
  task automatic run_playback(input bit bp, input int inj_wr_at, input int max_cycles);
    int rel;
    clear_stats();
    foreach (model_mem[i]) exp_q.push_back(model_mem[i]);
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    for (int c = 0; c < max_cycles && done_count == 0; c++) begin
      rel       = cyc - (start_cyc + 3);
      fifo_full = bp && ((rel >= 2 && rel <= 6) || rel == 10);
      host_wr   = (c == inj_wr_at);
      host_data = 32'hDEAD_BEEF;
      tick();
    end
    host_wr   = 1'b0;
    fifo_full = 1'b0;
    tests_run++;
    if (done_count == 0) begin
      tests_failed++;
      $display("FAIL playback_timeout: got no done within %0d cycles, required done", max_cycles);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    host_wr = 1'b0; host_data = '0; clr = 1'b0; start = 1'b0; fifo_full = 1'b0;
    clear_stats();
    repeat (3) tick();
    tests_run++;
    if ({fifo_wr, busy, done, wr_err} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got wr/busy/done/err=%b%b%b%b, required 0000",
               fifo_wr, busy, done, wr_err);
    end
    tests_run++;
    if (level !== '0) begin
      tests_failed++;
      $display("FAIL reset_level: got %0d, required 0", level);
    end
    tests_run++;
    if (fifo_din !== '0) begin
      tests_failed++;
      $display("FAIL reset_din: got %h, required 0", fifo_din);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_stream();
    load_words(8, 32'h1);
    tests_run++;
    if (level !== 11'd8) begin
      tests_failed++;
      $display("FAIL basic_level_loaded: got %0d, required 8", level);
    end
    run_playback(1'b0, -1, 40);
    tests_run++;
    if (wr_count != 8) begin
      tests_failed++;
      $display("FAIL basic_count: got %0d, required 8", wr_count);
    end
    tests_run++;
    if (first_wr_cyc - start_cyc != 3) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d, required 3", first_wr_cyc - start_cyc);
    end
    tests_run++;
    if (last_wr_cyc - first_wr_cyc != 7) begin
      tests_failed++;
      $display("FAIL basic_throughput: got span %0d, required 7", last_wr_cyc - first_wr_cyc);
    end
    tests_run++;
    if (done_cyc != last_wr_cyc + 1 || done_count != 1) begin
      tests_failed++;
      $display("FAIL basic_done: got cycle %0d count %0d, required cycle %0d count 1",
               done_cyc, done_count, last_wr_cyc + 1);
    end
    tick();
    tests_run++;
    if (level !== 11'd8 || busy !== 1'b0 || done_count != 1) begin
      tests_failed++;
      $display("FAIL basic_after: got level %0d busy %b dones %0d, required 8 0 1",
               level, busy, done_count);
    end
  endtask

  task automatic test_replay_and_run_drop();
    tests_run++;
    if (wr_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL replay_err_before: got %b, required 0", wr_err);
    end
    run_playback(1'b0, 1, 40);
    tests_run++;
    if (wr_count != 8 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL replay_count: got %0d left %0d, required 8 left 0", wr_count, exp_q.size());
    end
    tests_run++;
    if (wr_err !== 1'b1 || level !== 11'd8) begin
      tests_failed++;
      $display("FAIL run_drop: got err %b level %0d, required 1 8", wr_err, level);
    end
  endtask

  task automatic test_backpressure();
    do_clr();
    tests_run++;
    if (wr_err !== 1'b0 || level !== '0) begin
      tests_failed++;
      $display("FAIL clr_status: got err %b level %0d, required 0 0", wr_err, level);
    end
    load_words(16, 32'hA500_0000);
    run_playback(1'b1, -1, 60);
    tests_run++;
    if (wr_count != 16 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d left %0d, required 16 left 0", wr_count, exp_q.size());
    end
    tests_run++;
    if (last_wr_cyc - first_wr_cyc != 21) begin
      tests_failed++;
      $display("FAIL bp_duration: got span %0d, required 21", last_wr_cyc - first_wr_cyc);
    end
    tests_run++;
    if (done_cyc != last_wr_cyc + 1) begin
      tests_failed++;
      $display("FAIL bp_done: got cycle %0d, required %0d", done_cyc, last_wr_cyc + 1);
    end
  endtask

  task automatic test_empty_start();
    do_clr();
    run_playback(1'b0, -1, 10);
    tests_run++;
    if (wr_count != 0 || done_count != 1 || done_cyc != start_cyc + 1) begin
      tests_failed++;
      $display("FAIL empty_start: got writes %0d dones %0d delay %0d, required 0 1 1",
               wr_count, done_count, done_cyc - start_cyc);
    end
  endtask

  task automatic test_abort();
    int n_wr, n_done;
    do_clr();
    load_words(20, 32'h100);
    clear_stats();
    foreach (model_mem[i]) exp_q.push_back(model_mem[i]);
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100 && wr_count < 5; c++) tick();
    tests_run++;
    if (wr_count < 5) begin
      tests_failed++;
      $display("FAIL abort_timeout: got %0d writes, required 5", wr_count);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_q.delete();
    model_mem.delete();
    n_wr   = wr_count;
    n_done = done_count;
    repeat (10) tick();
    tests_run++;
    if (wr_count != n_wr || done_count != n_done) begin
      tests_failed++;
      $display("FAIL abort_quiet: got writes %0d dones %0d, required %0d %0d",
               wr_count, done_count, n_wr, n_done);
    end
    tests_run++;
    if (busy !== 1'b0 || level !== '0) begin
      tests_failed++;
      $display("FAIL abort_status: got busy %b level %0d, required 0 0", busy, level);
    end
    load_words(3, 32'h500);
    run_playback(1'b0, -1, 30);
    tests_run++;
    if (wr_count != 3 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL abort_reload: got %0d left %0d, required 3 left 0", wr_count, exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    do_clr();
    load_words(20, 32'h7000);
    clear_stats();
    foreach (model_mem[i]) exp_q.push_back(model_mem[i]);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100 && wr_count < 3; c++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({fifo_wr, busy, done, wr_err} !== 4'b0000 || level !== '0 || fifo_din !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: got wr%b busy%b done%b err%b level %0d din %h, required zeros",
               fifo_wr, busy, done, wr_err, level, fifo_din);
    end
    exp_q.delete();
    model_mem.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (level !== '0) begin
      tests_failed++;
      $display("FAIL post_reset_level: got %0d, required 0", level);
    end
    run_playback(1'b0, -1, 10);
    tests_run++;
    if (wr_count != 0 || done_count != 1) begin
      tests_failed++;
      $display("FAIL post_reset_start: got writes %0d dones %0d, required 0 1",
               wr_count, done_count);
    end
  endtask

  task automatic test_overflow();
    do_clr();
    load_words(1025, 32'h0);
    tests_run++;
    if (level !== 11'd1024 || wr_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow_status: got level %0d err %b, required 1024 1", level, wr_err);
    end
    run_playback(1'b0, -1, 1200);
    tests_run++;
    if (wr_count != 1024 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL overflow_stream: got %0d left %0d, required 1024 left 0",
               wr_count, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_replay_and_run_drop();
    test_backpressure();
    test_empty_start();
    test_abort();
    test_async_reset();
    test_overflow();
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/memory_playback.md
# memory_playback

Host-loaded 1k × 32-bit playback buffer: the transmit counterpart of the capture buffer that drains a FIFO into block RAM for host readback. The host writes a word sequence into local block RAM; on `start` the block streams every stored word, in write order, into a downstream FIFO while honouring `fifo_full`. Content is preserved after playback, so the same sequence can be replayed without reloading.

## Interface
- `ADDR_W`, 10, buffer address width; depth = 2^ADDR_W = 1024 words
- `DATA_W`, 32, word width

- `clk`  in  1  single system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `host_wr`  in  1  one-cycle strobe: append `host_data` at the write pointer
- `host_data`  in  DATA_W  word to append
- `clr`  in  1  synchronous clear: empties the buffer, aborts playback, clears error flags
- `start`  in  1  one-cycle strobe: begin playback from address 0
- `fifo_full`  in  1  downstream FIFO full
- `fifo_wr`  out  1  downstream FIFO write enable
- `fifo_din`  out  DATA_W  downstream FIFO data
- `level`  out  ADDR_W+1  number of stored words, 0..1024
- `busy`  out  1  playback in progress
- `done`  out  1  one-cycle pulse when the last word has been written to the FIFO
- `wr_err`  out  1  sticky: `host_wr` was dropped because the block was busy or full

## Operation
- Reset values: `level`=0, `busy`=0, `done`=0, `wr_err`=0, `fifo_wr`=0, `fifo_din`=0. Reset clears both pointers and the skid buffer. RAM contents are undefined.
- **Loading:** in IDLE, `host_wr` writes RAM[`level`] and increments `level`.
  - If `level`==1024, or the block is in RUN, the write is dropped and `wr_err` is set.
- **FSM states:** IDLE, RUN, DONE.
  - IDLE → RUN on `start` with `level`>0. The read pointer loads 0 and `busy` goes to 1.
  - IDLE → DONE on `start` with `level`==0. No FIFO writes occur.
  - RUN → DONE when the sent count equals `level`.
  - DONE → IDLE after one cycle. `done`=1 for that cycle only.
  - `start` while in RUN or DONE is ignored.
- **Read path:**
  - RAM read latency is 1 cycle. Read data is captured into a 2-entry skid buffer.
  - A read is issued when issued count < `level` and (skid occupancy + reads in flight − pop this cycle) < 2. The skid buffer therefore never overflows.
  - `fifo_wr` = skid non-empty AND NOT `fifo_full`. This is combinational, so no write is ever issued into a full FIFO.
  - `fifo_din` = skid head; it holds its value while `fifo_wr` is low.
  - A pop occurs exactly when `fifo_wr`=1.
- **`clr`:**
  - In any state: `level`←0, `wr_err`←0, pointers←0, skid flushed, next state IDLE, no `done` pulse.
  - `clr` has priority over `host_wr` and `start` in the same cycle.
- **Replay:** `start` after DONE streams the identical sequence again.
- **Width rules:** `level` is ADDR_W+1 bits so that 1024 is representable. The RAM write address is `level`[ADDR_W−1:0]. Pointers never wrap within one playback.

## Timing
- The edge that samples `start` enters RUN; the first read is issued in the following cycle.
- First `fifo_wr` is high 3 cycles after the `start` edge, provided `fifo_full`=0.
- Throughput is 1 word/cycle sustained while `fifo_full`=0.
- Stall: `fifo_full` high for N cycles delays the stream by exactly N cycles, with no loss or duplication.
- `done` is high in the cycle after the final `fifo_wr`. `busy` falls in the same cycle that `done` rises.
- `host_wr` in the same cycle as `start` from IDLE is accepted. Playback then uses the updated `level`.
- Reset asserted mid-playback: all outputs return to their reset values immediately (asynchronous); no `done` pulse.

## Structure
- Shared package holds:
  - FSM state encoding (S_IDLE, S_RUN, S_DONE)
  - default ADDR_W/DATA_W
  - the buffer-depth constant, shared with the capture buffer
- One sub-module, `playback_ram`: simple dual-port, 1-cycle synchronous read, 32 × 1024, same geometry as the capture RAM.
- Skid buffer and FSM stay in the top module.

## Test plan
- **Basic stream:** load 0x00000001..0x00000008, `fifo_full`=0, pulse `start` → 8 consecutive `fifo_wr` cycles with data 1..8 in order, first one 3 cycles after `start`; `done` pulses once; `level` stays 8.
- **Backpressure:** 16 words loaded; hold `fifo_full` high for cycles 2–6 and 10 of the stream → all 16 words delivered once, in order, with no `fifo_wr` while full; total duration is 16+6 cycles.
- **Full/overflow:** 1025 `host_wr` → `level`=1024 and `wr_err`=1; playback delivers words 0..1023; `host_wr` during RUN is dropped and sets `wr_err`.
- **Empty start:** `level`=0, pulse `start` → no `fifo_wr`; `done` 1 cycle later.
- **Abort:** `clr` at word 5 of 20 → `fifo_wr` low from the next cycle; `busy`=0, `level`=0, no `done`; a subsequent load of 3 words plus `start` delivers exactly those 3.
- **Async reset:** deassert `rst_n` mid-stream → all outputs are 0 without a clock edge; after release, `level`=0 and `start` produces `done` only.
